// File: rtl/data_cache_pkg.sv
// Shared geometry, state encoding and line-address mask for the data cache.
package data_cache_pkg;
   localparam int WORD_SIZE   = 16;
   localparam int LINE_WORDS  = 4;
   localparam int NUM_LINES   = 4;
   localparam int OFFSET_BITS = $clog2(LINE_WORDS);
   localparam int INDEX_BITS  = $clog2(NUM_LINES);
   localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
   localparam int LINE_BITS   = WORD_SIZE * LINE_WORDS;

   // Clears the offset bits to form the line-aligned fill address.
   localparam logic [WORD_SIZE-1:0] LINE_MASK =
      {{(WORD_SIZE-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;
endpackage

// File: rtl/data_cache_if.sv
// Datapath-side and memory-side signal bundle of the data cache.
interface data_cache_if;
   import data_cache_pkg::*;

   // Datapath holds readM/writeM/address/wdata stable until it samples ready=1;
   // memory holds its request view until it returns a single-cycle mem_ack.
   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] address;
   logic [WORD_SIZE-1:0] wdata;
   logic [WORD_SIZE-1:0] rdata;
   logic                 ready;
   logic                 mem_read;
   logic                 mem_write;
   logic [WORD_SIZE-1:0] mem_address;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [LINE_BITS-1:0] mem_rline;
   logic                 mem_ack;

   modport slave (
      input  readM, writeM, address, wdata, mem_rline, mem_ack,
      output rdata, ready, mem_read, mem_write, mem_address, mem_wdata
   );

   modport master (
      output readM, writeM, address, wdata, mem_rline, mem_ack,
      input  rdata, ready, mem_read, mem_write, mem_address, mem_wdata
   );
endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: one combinational read port, one write port
// performing either a full-line fill or a single-word update.
module data_cache_array
   import data_cache_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic [INDEX_BITS-1:0]  i_index,
   output logic                   o_rd_valid,
   output logic [TAG_BITS-1:0]    o_rd_tag,
   output logic [LINE_BITS-1:0]   o_rd_line,
   input  logic                   i_fill_en,
   input  logic [TAG_BITS-1:0]    i_fill_tag,
   input  logic [LINE_BITS-1:0]   i_fill_line,
   input  logic                   i_word_en,
   input  logic [OFFSET_BITS-1:0] i_word_offset,
   input  logic [WORD_SIZE-1:0]   i_word_data
);
   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
   logic [LINE_BITS-1:0] r_data [NUM_LINES];

   assign o_rd_valid = r_valid[i_index];
   assign o_rd_tag   = r_tag[i_index];
   assign o_rd_line  = r_data[i_index];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid <= '0;
      end else if (i_fill_en) begin
         r_valid[i_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are only observed behind a valid bit.
   always_ff @(posedge i_clk) begin
      if (i_fill_en) begin
         r_tag[i_index]  <= i_fill_tag;
         r_data[i_index] <= i_fill_line;
      end else if (i_word_en) begin
         r_data[i_index][i_word_offset*WORD_SIZE +: WORD_SIZE] <= i_word_data;
      end
   end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache (control FSM).
// Defining DATA_CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module data_cache
   import data_cache_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   data_cache_if.slave          bus,
   output state_t               o_dbg_state
`ifdef DATA_CACHE_STATS_EN
   ,
   output logic [WORD_SIZE-1:0] hit_count,
   output logic [WORD_SIZE-1:0] miss_count
`endif
);
   state_t                 r_state, w_state_nxt;
   logic [WORD_SIZE-1:0]   r_addr, r_wdata;
   logic [WORD_SIZE-1:0]   w_lookup_addr;
   logic [INDEX_BITS-1:0]  w_index;
   logic [TAG_BITS-1:0]    w_tag;
   logic [OFFSET_BITS-1:0] w_offset;
   logic                   w_rd_valid, w_hit;
   logic [TAG_BITS-1:0]    w_rd_tag;
   logic [LINE_BITS-1:0]   w_rd_line;
   logic [WORD_SIZE-1:0]   w_hit_word;
   logic                   w_latch, w_fill_en, w_word_en;
   logic                   w_ready, w_mem_read, w_mem_write;
   logic [WORD_SIZE-1:0]   w_rdata, w_mem_address, w_mem_wdata;

   // Outside IDLE only latched values matter, so the lookup follows r_addr.
   assign w_lookup_addr = (r_state == ST_IDLE) ? bus.address : r_addr;
   assign w_offset      = w_lookup_addr[OFFSET_BITS-1:0];
   assign w_index       = w_lookup_addr[OFFSET_BITS +: INDEX_BITS];
   assign w_tag         = w_lookup_addr[WORD_SIZE-1 -: TAG_BITS];
   assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
   assign w_hit_word    = w_rd_line[w_offset*WORD_SIZE +: WORD_SIZE];

   data_cache_array u_array (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_index       (w_index),
      .o_rd_valid    (w_rd_valid),
      .o_rd_tag      (w_rd_tag),
      .o_rd_line     (w_rd_line),
      .i_fill_en     (w_fill_en),
      .i_fill_tag    (w_tag),
      .i_fill_line   (bus.mem_rline),
      .i_word_en     (w_word_en),
      .i_word_offset (w_offset),
      .i_word_data   (r_wdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_addr  <= bus.address;
            r_wdata <= bus.wdata;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ready       = 1'b1;
      w_rdata       = '0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_mem_address = '0;
      w_mem_wdata   = '0;
      w_latch       = 1'b0;
      w_fill_en     = 1'b0;
      w_word_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.writeM) begin
               w_ready     = 1'b0;
               w_latch     = 1'b1;
               w_state_nxt = ST_WRITE;
            end else if (bus.readM) begin
               if (w_hit) begin
                  w_rdata = w_hit_word;
               end else begin
                  w_ready     = 1'b0;
                  w_latch     = 1'b1;
                  w_state_nxt = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            w_ready       = 1'b0;
            w_mem_read    = 1'b1;
            w_mem_address = r_addr & LINE_MASK;
            if (bus.mem_ack) begin
               w_fill_en   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            w_ready       = bus.mem_ack;
            w_mem_write   = 1'b1;
            w_mem_address = r_addr;
            w_mem_wdata   = r_wdata;
            if (bus.mem_ack) begin
               w_word_en   = w_hit;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.ready       = w_ready;
   assign bus.rdata       = w_rdata;
   assign bus.mem_read    = w_mem_read;
   assign bus.mem_write   = w_mem_write;
   assign bus.mem_address = w_mem_address;
   assign bus.mem_wdata   = w_mem_wdata;
   assign o_dbg_state     = r_state;

`ifdef DATA_CACHE_STATS_EN
   logic                 r_after_fill;
   logic [WORD_SIZE-1:0] r_hit_count, r_miss_count;
   logic                 w_hit_done, w_miss_start;

   assign w_hit_done   = (r_state == ST_IDLE) && bus.readM && !bus.writeM && w_hit;
   assign w_miss_start = (r_state == ST_IDLE) && (w_state_nxt == ST_FILL);

   // r_after_fill marks the retry cycle so the post-fill hit is not counted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_after_fill <= 1'b0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_after_fill <= (r_state == ST_FILL) && bus.mem_ack;
         if (w_hit_done && !r_after_fill && (r_hit_count != '1))
            r_hit_count <= r_hit_count + 1'b1;
         if (w_miss_start && (r_miss_count != '1))
            r_miss_count <= r_miss_count + 1'b1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic
// against a memory-plus-residency model of the cache.
module tb_data_cache;
   import data_cache_pkg::*;

   logic   clk = 1'b0;
   logic   reset_n = 1'b0;
   state_t dbg_state;
   data_cache_if bus();
`ifdef DATA_CACHE_STATS_EN
   logic [WORD_SIZE-1:0] hit_count, miss_count;
`endif

   data_cache dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
`ifdef DATA_CACHE_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int                   n_checks = 0;
   int                   n_errors = 0;
   logic [WORD_SIZE-1:0] mem [int];
   bit                   model_valid [NUM_LINES];
   logic [WORD_SIZE-1:0] model_line [NUM_LINES];
   int                   exp_hits = 0;
   int                   exp_misses = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WORD_SIZE-1:0] mem_rd(input logic [WORD_SIZE-1:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   function automatic int idx_of(input logic [WORD_SIZE-1:0] a);
      return (int'(a) / LINE_WORDS) % NUM_LINES;
   endfunction

   function automatic logic [WORD_SIZE-1:0] line_of(input logic [WORD_SIZE-1:0] a);
      return 16'(int'(a) - (int'(a) % LINE_WORDS));
   endfunction

   function automatic bit resident(input logic [WORD_SIZE-1:0] a);
      return model_valid[idx_of(a)] && (model_line[idx_of(a)] == line_of(a));
   endfunction

   function automatic logic [LINE_BITS-1:0] rline(input logic [WORD_SIZE-1:0] a);
      logic [LINE_BITS-1:0] r;
      r = '0;
      for (int w = 0; w < LINE_WORDS; w++)
         r[w*WORD_SIZE +: WORD_SIZE] = mem_rd(16'(int'(line_of(a)) + w));
      return r;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NUM_LINES; i++) model_valid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_ready"},   bus.ready, 1);
      chk({tag, "_memrd"},   bus.mem_read, 0);
      chk({tag, "_memwr"},   bus.mem_write, 0);
      chk({tag, "_memaddr"}, bus.mem_address, 0);
      chk({tag, "_memwd"},   bus.mem_wdata, 0);
      chk({tag, "_rdata"},   bus.rdata, 0);
      chk({tag, "_state"},   dbg_state, ST_IDLE);
   endtask

   // Hit: one-cycle completion. Miss: ack in the d-th FILL cycle, retry hits next.
   task automatic do_read(input logic [WORD_SIZE-1:0] a, input int d);
      bit                   hit;
      logic [WORD_SIZE-1:0] la;
      hit = resident(a);
      la  = line_of(a);
      @(posedge clk); #1;
      bus.readM   = 1'b1;
      bus.address = a;
      @(negedge clk);
      chk("rd_ready", bus.ready, hit);
      if (hit) begin
         exp_hits++;
         chk("rd_hit_data", bus.rdata, mem_rd(a));
         chk("rd_hit_memrd", bus.mem_read, 0);
      end else begin
         exp_misses++;
         for (int c = 1; c <= d; c++) begin
            @(posedge clk); #1;
            if (c == d) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rline = rline(a);
            end else begin
               bus.mem_rline = {$urandom, $urandom};
            end
            @(negedge clk);
            chk("fill_memrd", bus.mem_read, 1);
            chk("fill_memwr", bus.mem_write, 0);
            chk("fill_addr", bus.mem_address, la);
            chk("fill_ready", bus.ready, 0);
         end
         @(posedge clk); #1;
         bus.mem_ack   = 1'b0;
         bus.mem_rline = {$urandom, $urandom};
         model_valid[idx_of(a)] = 1'b1;
         model_line[idx_of(a)]  = la;
         @(negedge clk);
         chk("retry_ready", bus.ready, 1);
         chk("retry_data", bus.rdata, mem_rd(a));
         chk("retry_memrd", bus.mem_read, 0);
      end
      @(posedge clk); #1;
      bus.readM = 1'b0;
   endtask

   task automatic do_write(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] data,
                           input int d);
      @(posedge clk); #1;
      bus.writeM  = 1'b1;
      bus.address = a;
      bus.wdata   = data;
      @(negedge clk);
      chk("wr_ready0", bus.ready, 0);
      for (int c = 1; c <= d; c++) begin
         @(posedge clk); #1;
         bus.mem_ack = (c == d);
         @(negedge clk);
         chk("wr_memwr", bus.mem_write, 1);
         chk("wr_memrd", bus.mem_read, 0);
         chk("wr_addr", bus.mem_address, a);
         chk("wr_data", bus.mem_wdata, data);
         chk("wr_ready", bus.ready, (c == d));
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      bus.writeM  = 1'b0;
      mem[int'(a)] = data;
   endtask

   task automatic check_stats(input string tag);
`ifdef DATA_CACHE_STATS_EN
      @(negedge clk);
      chk({tag, "_hits"},   hit_count, exp_hits);
      chk({tag, "_misses"}, miss_count, exp_misses);
`else
      @(negedge clk);
      chk({tag, "_idle"}, dbg_state, ST_IDLE);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WORD_SIZE-1:0] a;
      int                   d;
      bus.readM     = 1'b0;
      bus.writeM    = 1'b0;
      bus.address   = '0;
      bus.wdata     = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rline = '0;
      model_clear();
      #1;
      check_quiet("reset");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Directed scenarios
      do_read(16'h0012, 3);
      do_read(16'h0013, 2);
      do_write(16'h0011, 16'hBEEF, 2);
      do_read(16'h0011, 1);
      do_read(16'h0010, 1);
      check_stats("plan");
      do_write(16'h0050, 16'h1234, 3);
      do_read(16'h0012, 1);
      do_read(16'h0050, 2);
      do_read(16'h0010, 2);
      do_read(16'hFFFF, 2);
      do_read(16'hFFFC, 1);

      // Reset two cycles into a FILL
      @(posedge clk); #1;
      bus.readM   = 1'b1;
      bus.address = 16'h0032;
      @(negedge clk);
      chk("rst_miss_ready", bus.ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_fill_memrd", bus.mem_read, 1);
      #2;
      reset_n   = 1'b0;
      bus.readM = 1'b0;
      #1;
      check_quiet("midfill");
      model_clear();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack   = 1'b1;
      bus.mem_rline = {$urandom, $urandom};
      @(negedge clk);
      chk("stray_ack_memrd", bus.mem_read, 0);
      chk("stray_ack_ready", bus.ready, 1);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      check_stats("after_rst");
      do_read(16'h0012, 2);

      // Random traffic
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(16'hFFF0, 16'hFFFF));
         else                           a = 16'($urandom_range(0, 63));
         d = int'($urandom_range(1, 4));
         if ($urandom_range(0, 2) == 0) do_write(a, 16'($urandom), d);
         else                           do_read(a, d);
      end
      check_stats("final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
